// File: rtl/arb41_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
package arb41_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Pointer value after reset, so that requester 0 has first priority.
  localparam logic [1:0] LAST_RST = 2'd3;

  // Round-robin pick: the first set bit in the order last+1, last+2, last+3, last.
  // Walk the order backwards so the last hit is the highest priority one.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] w;
    logic [1:0] idx;
    w = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) w = idx;
    end
    return w;
  endfunction

endpackage

// File: rtl/arb41_mux41.sv
// 4:1 data multiplexer for the shared output path.
module mux41 #(
  parameter int Size = 8
) (
  input  logic [1:0]      S,
  input  logic [Size-1:0] A0,
  input  logic [Size-1:0] A1,
  input  logic [Size-1:0] A2,
  input  logic [Size-1:0] A3,
  output logic [Size-1:0] Y
);

  // Steer the selected requester bus onto Y.
  always_comb begin
    Y = A0;
    case (S)
      2'd0: Y = A0;
      2'd1: Y = A1;
      2'd2: Y = A2;
      2'd3: Y = A3;
      default: Y = A0;
    endcase
  end

endmodule

// File: rtl/arb41.sv
// 4-requester round-robin arbiter with bounded tenure and a shared data path.
module arb41
  import arb41_pkg::*;
#(
  parameter int Size    = 8,
  parameter int MaxHold = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [Size-1:0] A0,
  input  logic [Size-1:0] A1,
  input  logic [Size-1:0] A2,
  input  logic [Size-1:0] A3,
  output logic [3:0]      gnt,
  output logic [1:0]      sel,
  output logic            busy,
  output logic [Size-1:0] Y
);

  // Last cycle of a tenure; the owner is released on the edge after it.
  localparam logic [3:0] HOLD_LAST = 4'(MaxHold - 1);

  state_t     state, nxt_state;
  logic [3:0] cnt, nxt_cnt;
  logic [1:0] last, nxt_last;
  logic [3:0] nxt_gnt;
  logic [1:0] nxt_sel;
  logic       nxt_busy;
  logic [1:0] win;

  assign win = rr_pick(req, last);

  // Next-state and registered-output decode; release and forced release share one path.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_last  = last;
    nxt_gnt   = gnt;
    nxt_sel   = sel;
    nxt_busy  = busy;
    case (state)
      IDLE: begin
        if (|req) begin
          nxt_state = BUSY;
          nxt_gnt   = 4'b0001 << win;
          nxt_sel   = win;
          nxt_busy  = 1'b1;
          nxt_last  = win;
          nxt_cnt   = 4'd0;
        end else begin
          nxt_gnt  = 4'd0;
          nxt_busy = 1'b0;
        end
      end
      BUSY: begin
        if (!req[sel] || cnt == HOLD_LAST) begin
          nxt_state = IDLE;
          nxt_gnt   = 4'd0;
          nxt_busy  = 1'b0;
        end else begin
          nxt_cnt = cnt + 4'd1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_gnt   = 4'd0;
        nxt_busy  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over everything, including an active grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'd0;
      sel   <= 2'd0;
      busy  <= 1'b0;
      cnt   <= 4'd0;
      last  <= LAST_RST;
    end else begin
      state <= nxt_state;
      gnt   <= nxt_gnt;
      sel   <= nxt_sel;
      busy  <= nxt_busy;
      cnt   <= nxt_cnt;
      last  <= nxt_last;
    end
  end

  mux41 #(.Size(Size)) u_mux (
    .S (sel),
    .A0(A0),
    .A1(A1),
    .A2(A2),
    .A3(A3),
    .Y (Y)
  );

endmodule

// File: tb/tb_arb41.sv
// Scoreboard bench for arb41: each driven cycle pushes its expected outputs, popped after the edge.
module tb_arb41;

  typedef struct {
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] sel;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] A0, A1, A2, A3;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic [7:0] Y;

  logic [7:0] a_exp [4];
  exp_t       sb [$];
  int         total = 0;
  int         bad   = 0;

  arb41 #(.Size(8), .MaxHold(4)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .A0  (A0),
    .A1  (A1),
    .A2  (A2),
    .A3  (A3),
    .gnt (gnt),
    .sel (sel),
    .busy(busy),
    .Y   (Y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: push the expectation for this edge, clock, then pop and compare mid-cycle.
  task automatic tick(input string tag, input logic [3:0] g, input logic b, input logic [1:0] s);
    exp_t e;
    e.gnt = g; e.busy = b; e.sel = s;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, ".gnt"}, 32'(gnt), 32'(e.gnt));
    chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
    chk({tag, ".sel"}, 32'(sel), 32'(e.sel));
    if (e.busy) chk({tag, ".y"}, 32'(Y), 32'(a_exp[e.sel]));
  endtask

  task automatic tenure(input string tag, input int n, input logic [1:0] w);
    for (int i = 0; i < n; i++) tick(tag, 4'b0001 << w, 1'b1, w);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'd0;
    tick("reset", 4'd0, 1'b0, 2'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_exp[0] = 8'hA5; a_exp[1] = 8'h11; a_exp[2] = 8'h3C; a_exp[3] = 8'hC3;
    A0 = a_exp[0]; A1 = a_exp[1]; A2 = a_exp[2]; A3 = a_exp[3];
    rst = 1'b1; req = 4'd0;
    @(negedge clk);

    // Two requesters held: forced releases alternate 0 and 2.
    do_reset();
    req = 4'b0101;
    tenure("r0101_a", 4, 2'd0);
    tick("r0101_idle1", 4'd0, 1'b0, 2'd0);
    tenure("r0101_b", 4, 2'd2);
    tick("r0101_idle2", 4'd0, 1'b0, 2'd2);
    tenure("r0101_c", 1, 2'd0);

    // All requesting: strict rotation 0,1,2,3,0 with one idle gap each.
    do_reset();
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      tenure("r1111", 4, 2'(t));
      tick("r1111_gap", 4'd0, 1'b0, 2'(t));
    end

    // Owner release after two cycles; sel retained in IDLE.
    do_reset();
    req = 4'b0010;
    tenure("rel", 2, 2'd1);
    req = 4'b0000;
    tick("rel_drop", 4'd0, 1'b0, 2'd1);
    tick("rel_idle", 4'd0, 1'b0, 2'd1);

    // Requester 2 owns; other request bits toggling must not disturb it.
    do_reset();
    req = 4'b0100;
    tenure("tog", 1, 2'd2);
    req = 4'b0101; tenure("tog", 1, 2'd2);
    req = 4'b0100; tenure("tog", 1, 2'd2);
    req = 4'b0101; tenure("tog", 1, 2'd2);
    req = 4'b0000;
    tick("tog_end", 4'd0, 1'b0, 2'd2);

    // Reset during the second BUSY cycle of requester 1; pointer back to 3.
    do_reset();
    req = 4'b0010;
    tenure("rstbusy", 2, 2'd1);
    rst = 1'b1; req = 4'b1111;
    tick("rstbusy_drop", 4'd0, 1'b0, 2'd0);
    rst = 1'b0;
    tenure("rstbusy_first", 1, 2'd0);

    // Sole requester 3 re-granted after the mandatory idle cycle.
    do_reset();
    req = 4'b1000;
    tenure("sole_a", 4, 2'd3);
    tick("sole_gap", 4'd0, 1'b0, 2'd3);
    tenure("sole_b", 4, 2'd3);
    tick("sole_gap2", 4'd0, 1'b0, 2'd3);

    // Owner release with another requester waiting: next grant goes to it.
    do_reset();
    req = 4'b0011;
    tenure("hand_a", 1, 2'd0);
    req = 4'b0010;
    tick("hand_gap", 4'd0, 1'b0, 2'd0);
    tenure("hand_b", 1, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
